mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one Wishbone-classic port between instruction fetch and the LSU.
// Each access runs as a full bus cycle with registered responses and a bounded wait.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_dat_o,
  output logic        if_ack_o,
  output logic        if_err_o,
  input  logic        lsu_re_i,
  input  logic        lsu_we_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [3:0]  lsu_sel_i,
  input  logic [31:0] lsu_dat_i,
  output logic [31:0] lsu_dat_o,
  output logic        lsu_ack_o,
  output logic        lsu_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {IDLE, BUS_IF, BUS_LSU, RESP} state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q;
  logic [TO_W-1:0] cnt_q;
  logic            last_lsu_q;
  logic            cyc_q;
  logic            we_q;
  logic [31:0]     adr_q;
  logic [3:0]      sel_q;
  logic [31:0]     wdat_q;
  logic [31:0]     if_dat_q;
  logic [31:0]     lsu_dat_q;
  logic            if_ack_q;
  logic            if_err_q;
  logic            lsu_ack_q;
  logic            lsu_err_q;

  logic lsu_req;
  logic grant_lsu;
  logic grant_if;
  logic timed_out;

  // When both sides want the bus, the one that lost last time wins.
  always_comb begin
    lsu_req   = lsu_re_i | lsu_we_i;
    grant_lsu = lsu_req & (~if_req_i | ~last_lsu_q);
    grant_if  = if_req_i & ~grant_lsu;
    timed_out = (cnt_q == TO_LAST);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_lsu_q <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= 32'h0;
      sel_q      <= 4'h0;
      wdat_q     <= 32'h0;
      if_dat_q   <= 32'h0;
      lsu_dat_q  <= 32'h0;
      if_ack_q   <= 1'b0;
      if_err_q   <= 1'b0;
      lsu_ack_q  <= 1'b0;
      lsu_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_lsu) begin
            state_q    <= BUS_LSU;
            cyc_q      <= 1'b1;
            we_q       <= lsu_we_i;
            adr_q      <= lsu_addr_i;
            sel_q      <= lsu_sel_i;
            wdat_q     <= lsu_dat_i;
            cnt_q      <= '0;
            last_lsu_q <= 1'b1;
          end else if (grant_if) begin
            state_q    <= BUS_IF;
            cyc_q      <= 1'b1;
            we_q       <= 1'b0;
            adr_q      <= if_addr_i & 32'hFFFF_FFFC;
            sel_q      <= 4'hF;
            cnt_q      <= '0;
            last_lsu_q <= 1'b0;
          end
        end
        BUS_IF, BUS_LSU: begin
          // Error outranks a simultaneous ack; a timeout only fires with neither present.
          if (wb_err_i || (!wb_ack_i && timed_out)) begin
            cyc_q   <= 1'b0;
            state_q <= RESP;
            if (state_q == BUS_LSU) lsu_err_q <= 1'b1;
            else                    if_err_q  <= 1'b1;
          end else if (wb_ack_i) begin
            cyc_q   <= 1'b0;
            state_q <= RESP;
            if (state_q == BUS_LSU) begin
              lsu_ack_q <= 1'b1;
              if (!we_q) lsu_dat_q <= wb_dat_i;
            end else begin
              if_ack_q <= 1'b1;
              if_dat_q <= wb_dat_i;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if_ack_q  <= 1'b0;
          if_err_q  <= 1'b0;
          lsu_ack_q <= 1'b0;
          lsu_err_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_adr_o  = adr_q;
  assign wb_sel_o  = sel_q;
  assign wb_dat_o  = wdat_q;
  assign if_dat_o  = if_dat_q;
  assign if_ack_o  = if_ack_q;
  assign if_err_o  = if_err_q;
  assign lsu_dat_o = lsu_dat_q;
  assign lsu_ack_o = lsu_ack_q;
  assign lsu_err_o = lsu_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requester queues and a bus responder driven per cycle,
// checked against a transaction-level model of arbitration, bus fields and responses.
module tb_mem_port_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_dat_o;
  logic        if_ack_o, if_err_o;
  logic        lsu_re_i, lsu_we_i;
  logic [31:0] lsu_addr_i;
  logic [3:0]  lsu_sel_i;
  logic [31:0] lsu_dat_i;
  logic [31:0] lsu_dat_o;
  logic        lsu_ack_o, lsu_err_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_dat_o(if_dat_o),
    .if_ack_o(if_ack_o), .if_err_o(if_err_o),
    .lsu_re_i(lsu_re_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
    .lsu_sel_i(lsu_sel_i), .lsu_dat_i(lsu_dat_i), .lsu_dat_o(lsu_dat_o),
    .lsu_ack_o(lsu_ack_o), .lsu_err_o(lsu_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  // kind: 0 fetch, 1 LSU read, 2 LSU write; resp: 0 ack, 1 err, 2 ack+err, 3 silent
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          resp;
    int          delay;
    logic [31:0] rdata;
  } txn_t;

  txn_t        if_q[$];
  txn_t        lsu_q[$];
  txn_t        cur;
  int          total = 0;
  int          bad = 0;
  bit          last_lsu, cyc_prev, cur_valid, cur_is_lsu, rand_mode;
  int          cyc_len, if_gap, lsu_gap, n_txn;
  logic [31:0] m_if_dat, m_lsu_dat, m_wb_dat;

  function automatic txn_t mk(input int kind, input logic [31:0] addr, input logic [3:0] sel,
                              input logic [31:0] wdata, input int resp, input int delay,
                              input logic [31:0] rdata);
    txn_t t;
    t.kind = kind; t.addr = addr; t.sel = sel; t.wdata = wdata;
    t.resp = resp; t.delay = delay; t.rdata = rdata;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    last_lsu = 1'b0; m_if_dat = '0; m_lsu_dat = '0; m_wb_dat = '0;
    cyc_prev = 1'b0; cur_valid = 1'b0; if_gap = 0; lsu_gap = 0;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1; if_req_i = 1'b0; lsu_re_i = 1'b0; lsu_we_i = 1'b0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic drive_reqs();
    if (if_gap > 0) if_gap--;
    if (lsu_gap > 0) lsu_gap--;
    if (if_gap == 0 && if_q.size() != 0) begin
      if_req_i = 1'b1; if_addr_i = if_q[0].addr;
    end else begin
      if_req_i = 1'b0;
    end
    if (lsu_gap == 0 && lsu_q.size() != 0) begin
      lsu_re_i = (lsu_q[0].kind == 1); lsu_we_i = (lsu_q[0].kind == 2);
      lsu_addr_i = lsu_q[0].addr; lsu_sel_i = lsu_q[0].sel; lsu_dat_i = lsu_q[0].wdata;
    end else begin
      lsu_re_i = 1'b0; lsu_we_i = 1'b0;
    end
  endtask

  task automatic check_quiet(input string tag);
    chkb({tag, "_cyc"}, wb_cyc_o, 1'b0);
    chkb({tag, "_if_ack"}, if_ack_o, 1'b0);
    chkb({tag, "_if_err"}, if_err_o, 1'b0);
    chkb({tag, "_lsu_ack"}, lsu_ack_o, 1'b0);
    chkb({tag, "_lsu_err"}, lsu_err_o, 1'b0);
    chk({tag, "_if_dat"}, if_dat_o, m_if_dat);
    chk({tag, "_lsu_dat"}, lsu_dat_o, m_lsu_dat);
  endtask

  // Runs until both requester queues drain; checks every cycle against the model.
  task automatic run_queues(input int budget);
    int   n;
    bit   if_pend, lsu_pend, ok;
    logic e_ia, e_ie, e_la, e_le;
    txn_t dummy;
    n = 0;
    drive_reqs();
    while ((if_q.size() != 0 || lsu_q.size() != 0 || cur_valid) && n < budget) begin
      tick();
      n++;
      e_ia = 1'b0; e_ie = 1'b0; e_la = 1'b0; e_le = 1'b0;
      chkb("stb_eq_cyc", wb_stb_o, wb_cyc_o);
      if (wb_cyc_o && !cyc_prev) begin
        if_pend  = if_req_i;
        lsu_pend = lsu_re_i | lsu_we_i;
        chkb("grant_has_req", if_pend | lsu_pend, 1'b1);
        cur_is_lsu = lsu_pend && (!if_pend || !last_lsu);
        if (cur_is_lsu && lsu_q.size() != 0) begin
          cur = lsu_q[0]; m_wb_dat = cur.wdata;
        end else if (!cur_is_lsu && if_q.size() != 0) begin
          cur = if_q[0];
        end
        last_lsu = cur_is_lsu; cur_valid = 1'b1; cyc_len = 0;
      end
      if (wb_cyc_o) begin
        cyc_len++;
        chkb("bus_we", wb_we_o, cur_is_lsu && cur.kind == 2);
        chk("bus_adr", wb_adr_o, cur_is_lsu ? cur.addr : (cur.addr & 32'hFFFF_FFFC));
        chk("bus_sel", 32'(wb_sel_o), cur_is_lsu ? 32'(cur.sel) : 32'hF);
        chk("bus_dat", wb_dat_o, m_wb_dat);
      end else if (cyc_prev) begin
        chk("cyc_len", cyc_len, (cur.resp == 3) ? TO : cur.delay + 1);
        ok = (cur.resp == 0);
        if (ok && cur.kind != 2) begin
          if (cur_is_lsu) m_lsu_dat = cur.rdata;
          else            m_if_dat  = cur.rdata;
        end
        e_ia = !cur_is_lsu && ok;  e_ie = !cur_is_lsu && !ok;
        e_la = cur_is_lsu && ok;   e_le = cur_is_lsu && !ok;
        n_txn++;
        $display("txn %0d: %s kind=%0d adr=%h resp=%0d cyc_len=%0d", n_txn,
                 cur_is_lsu ? "LSU" : "IF ", cur.kind, cur.addr, cur.resp, cyc_len);
        if (cur_is_lsu) begin
          if (lsu_q.size() != 0) dummy = lsu_q.pop_front();
          if (rand_mode) lsu_gap = $urandom_range(0, 3);
        end else begin
          if (if_q.size() != 0) dummy = if_q.pop_front();
          if (rand_mode) if_gap = $urandom_range(0, 3);
        end
        cur_valid = 1'b0;
      end
      chkb("if_ack", if_ack_o, e_ia);
      chkb("if_err", if_err_o, e_ie);
      chkb("lsu_ack", lsu_ack_o, e_la);
      chkb("lsu_err", lsu_err_o, e_le);
      chk("if_dat", if_dat_o, m_if_dat);
      chk("lsu_dat", lsu_dat_o, m_lsu_dat);
      if (wb_cyc_o && cur.resp != 3 && cyc_len >= cur.delay + 1) begin
        wb_ack_i = (cur.resp == 0 || cur.resp == 2);
        wb_err_i = (cur.resp == 1 || cur.resp == 2);
        wb_dat_i = cur.rdata;
      end else begin
        // Stray responses while no cycle is open must be ignored.
        wb_ack_i = rand_mode && !wb_cyc_o && ($urandom_range(0, 3) == 0);
        wb_err_i = rand_mode && !wb_cyc_o && ($urandom_range(0, 5) == 0);
        wb_dat_i = $urandom;
      end
      cyc_prev = wb_cyc_o;
      drive_reqs();
    end
    chkb("all_done", (if_q.size() == 0 && lsu_q.size() == 0 && !cur_valid), 1'b1);
    if_q.delete(); lsu_q.delete(); cur_valid = 1'b0;
    if_req_i = 1'b0; lsu_re_i = 1'b0; lsu_we_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    tick(); check_quiet("post1");
    tick(); check_quiet("post2");
    cyc_prev = wb_cyc_o;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   r;
    txn_t t;
    rst_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0; lsu_re_i = 1'b0; lsu_we_i = 1'b0;
    lsu_addr_i = '0; lsu_sel_i = '0; lsu_dat_i = '0; wb_dat_i = '0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; rand_mode = 1'b0; n_txn = 0;

    apply_reset();
    chkb("rst_cyc", wb_cyc_o, 1'b0);
    chkb("rst_stb", wb_stb_o, 1'b0);
    chkb("rst_we", wb_we_o, 1'b0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_sel", 32'(wb_sel_o), 32'h0);
    chk("rst_wdat", wb_dat_o, 32'h0);
    check_quiet("rst");

    lsu_q.push_back(mk(2, 32'h0000_0100, 4'b0011, 32'hBEEF_BEEF, 0, 2, 32'h1234_5678));
    run_queues(50);

    if_q.push_back(mk(0, 32'h0000_2003, 4'hF, 32'h0, 0, 0, 32'h0000_0013));
    run_queues(50);

    apply_reset();
    for (int i = 0; i < 4; i++) begin
      if_q.push_back(mk(0, 32'h0000_4000 + 32'(i * 4), 4'hF, 32'h0, 0, 0, 32'hA000_0000 + 32'(i)));
      lsu_q.push_back(mk(1, 32'h0000_8000 + 32'(i * 4), 4'hF, 32'h5500_0000 + 32'(i), 0, 0,
                         32'hB000_0000 + 32'(i)));
    end
    run_queues(200);

    lsu_q.push_back(mk(1, 32'h0000_0200, 4'hF, 32'h0, 3, 0, 32'hCAFE_0001));
    run_queues(50);

    lsu_q.push_back(mk(1, 32'h0000_0300, 4'hF, 32'h7777_7777, 2, 1, 32'hDEAD_0000));
    run_queues(50);
    if_q.push_back(mk(0, 32'h0000_0400, 4'hF, 32'h0, 2, 0, 32'hDEAD_0001));
    run_queues(50);

    rand_mode = 1'b1;
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      t = mk(0, $urandom, 4'($urandom_range(1, 15)), $urandom, (r < 7) ? 0 : r - 6,
             $urandom_range(0, 2), $urandom);
      if ($urandom_range(0, 1) == 1) begin
        t.kind = $urandom_range(1, 2);
        t.addr = t.addr & 32'hFFFF_FFFC;
        lsu_q.push_back(t);
      end else begin
        if_q.push_back(t);
      end
    end
    run_queues(2000);
    rand_mode = 1'b0;

    if_req_i = 1'b1; if_addr_i = 32'h0000_3004; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!wb_cyc_o && n < 10);
    chkb("midrst_cyc_seen", wb_cyc_o, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; if_req_i = 1'b0;
    model_reset();
    chkb("midrst_stb", wb_stb_o, 1'b0);
    check_quiet("midrst");
    tick();
    check_quiet("midrst_after");
    if_q.push_back(mk(0, 32'h0000_5008, 4'hF, 32'h0, 0, 1, 32'h0BAD_F00D));
    run_queues(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
